// File: rtl/text_write_ctrl.sv
// Write-side sequencer for the 80x30 text-mode tile RAM.
// Owns the write cursor, interprets control codes, runs the clear sweep
// and drives the tile RAM write port one cell per cycle.
module text_write_ctrl #(
  parameter int          MAX_X      = 80,
  parameter int          MAX_Y      = 30,
  parameter logic [6:0]  BLANK_CHAR = 7'h20
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_char_valid,
  input  logic [6:0]  i_char_data,
  output logic        o_char_ready,
  input  logic        i_clr_req,
  output logic        o_ram_we,
  output logic [11:0] o_ram_addr,
  output logic [6:0]  o_ram_din,
  output logic [6:0]  o_cur_x,
  output logic [4:0]  o_cur_y,
  output logic        o_busy
);

  typedef enum logic {S_CLEAR, S_IDLE} state_t;

  localparam logic [6:0] LAST_X    = 7'(MAX_X - 1);
  localparam logic [4:0] LAST_Y    = 5'(MAX_Y - 1);
  // The sweep row counter runs one past the last row; that extra value
  // marks "every cell written" and gives the sweep its closing cycle.
  localparam logic [4:0] SWEEP_END = 5'(MAX_Y);

  state_t      r_state, w_stateNext;
  logic [6:0]  r_sweepX, w_sweepXNext;
  logic [4:0]  r_sweepY, w_sweepYNext;
  logic [6:0]  r_curX, w_curXNext;
  logic [4:0]  r_curY, w_curYNext;
  logic        r_we, w_weNext;
  logic [11:0] r_addr, w_addrNext;
  logic [6:0]  r_din, w_dinNext;
  logic        r_busy, w_busyNext;

  logic [6:0]  w_curXDec;
  logic [4:0]  w_curYDec;
  logic        w_printable;

  assign w_curXDec    = r_curX - 7'd1;
  assign w_curYDec    = r_curY - 5'd1;
  assign w_printable  = (i_char_data >= 7'h20) && (i_char_data <= 7'h7E);
  assign o_char_ready = (r_state == S_IDLE) && !i_clr_req;

  assign o_ram_we   = r_we;
  assign o_ram_addr = r_addr;
  assign o_ram_din  = r_din;
  assign o_cur_x    = r_curX;
  assign o_cur_y    = r_curY;
  assign o_busy     = r_busy;

  // State register; reset always restarts the clear sweep.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_CLEAR;
    else         r_state <= w_stateNext;
  end

  // Next-state and next-output logic: sweep stepping, control codes, cursor motion.
  always_comb begin
    w_stateNext  = r_state;
    w_sweepXNext = r_sweepX;
    w_sweepYNext = r_sweepY;
    w_curXNext   = r_curX;
    w_curYNext   = r_curY;
    w_weNext     = 1'b0;
    w_addrNext   = r_addr;
    w_dinNext    = r_din;
    w_busyNext   = r_busy;

    case (r_state)
      S_CLEAR: begin
        if (r_sweepY == SWEEP_END) begin
          w_stateNext = S_IDLE;
          w_busyNext  = 1'b0;
          w_curXNext  = 7'd0;
          w_curYNext  = 5'd0;
        end else begin
          w_weNext   = 1'b1;
          w_addrNext = {r_sweepY, r_sweepX};
          w_dinNext  = BLANK_CHAR;
          if (r_sweepX == LAST_X) begin
            w_sweepXNext = 7'd0;
            w_sweepYNext = r_sweepY + 5'd1;
          end else begin
            w_sweepXNext = r_sweepX + 7'd1;
          end
        end
      end

      S_IDLE: begin
        if (i_clr_req || (i_char_valid && i_char_data == 7'h0C)) begin
          w_stateNext  = S_CLEAR;
          w_sweepXNext = 7'd0;
          w_sweepYNext = 5'd0;
          w_busyNext   = 1'b1;
        end else if (i_char_valid) begin
          case (i_char_data)
            7'h0D: w_curXNext = 7'd0;
            7'h0A: begin
              w_curXNext = 7'd0;
              w_curYNext = (r_curY == LAST_Y) ? 5'd0 : r_curY + 5'd1;
            end
            7'h08: begin
              if (r_curX != 7'd0) begin
                w_curXNext = w_curXDec;
                w_weNext   = 1'b1;
                w_addrNext = {r_curY, w_curXDec};
                w_dinNext  = BLANK_CHAR;
              end else if (r_curY != 5'd0) begin
                w_curXNext = LAST_X;
                w_curYNext = w_curYDec;
                w_weNext   = 1'b1;
                w_addrNext = {w_curYDec, LAST_X};
                w_dinNext  = BLANK_CHAR;
              end
            end
            default: begin
              if (w_printable) begin
                w_weNext   = 1'b1;
                w_addrNext = {r_curY, r_curX};
                w_dinNext  = i_char_data;
                if (r_curX == LAST_X) begin
                  w_curXNext = 7'd0;
                  w_curYNext = (r_curY == LAST_Y) ? 5'd0 : r_curY + 5'd1;
                end else begin
                  w_curXNext = r_curX + 7'd1;
                end
              end
            end
          endcase
        end
      end

      default: w_stateNext = S_CLEAR;
    endcase
  end

  // Registered datapath: sweep counter, cursor and RAM write port.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sweepX <= 7'd0;
      r_sweepY <= 5'd0;
      r_curX   <= 7'd0;
      r_curY   <= 5'd0;
      r_we     <= 1'b0;
      r_addr   <= 12'd0;
      r_din    <= 7'd0;
      r_busy   <= 1'b1;
    end else begin
      r_sweepX <= w_sweepXNext;
      r_sweepY <= w_sweepYNext;
      r_curX   <= w_curXNext;
      r_curY   <= w_curYNext;
      r_we     <= w_weNext;
      r_addr   <= w_addrNext;
      r_din    <= w_dinNext;
      r_busy   <= w_busyNext;
    end
  end

endmodule

// File: tb/tb_text_write_ctrl.sv
// Testbench for text_write_ctrl: directed scenarios plus a random character
// stream, all checked every cycle against a linear-index screen model.
module tb_text_write_ctrl;

  logic        clk;
  logic        i_reset;
  logic        i_char_valid;
  logic [6:0]  i_char_data;
  logic        o_char_ready;
  logic        i_clr_req;
  logic        o_ram_we;
  logic [11:0] o_ram_addr;
  logic [6:0]  o_ram_din;
  logic [6:0]  o_cur_x;
  logic [4:0]  o_cur_y;
  logic        o_busy;

  int total = 0;
  int bad   = 0;

  // Model state: clearing flag, sweep cell index (0..2400), cursor and expected outputs.
  bit mClearing;
  int mIdx;
  int mCx, mCy;
  int eWe, eAddr, eDin, eBusy;

  // Sweep tally used to confirm full, distinct coverage of the screen.
  bit covered [4096];
  int pulses, distinct;

  text_write_ctrl dut (
    .i_clk        (clk),
    .i_reset      (i_reset),
    .i_char_valid (i_char_valid),
    .i_char_data  (i_char_data),
    .o_char_ready (o_char_ready),
    .i_clr_req    (i_clr_req),
    .o_ram_we     (o_ram_we),
    .o_ram_addr   (o_ram_addr),
    .o_ram_din    (o_ram_din),
    .o_cur_x      (o_cur_x),
    .o_cur_y      (o_cur_y),
    .o_busy       (o_busy)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int cellAddr(input int lin);
    return (lin / 80) * 128 + (lin % 80);
  endfunction

  // Behavioural model of one clock edge, in terms of a linear cell index.
  task automatic modelStep(input logic rst, input logic valid, input logic [6:0] data, input logic clr);
    int lin;
    if (rst) begin
      mClearing = 1; mIdx = 0; mCx = 0; mCy = 0;
      eWe = 0; eAddr = 0; eDin = 0; eBusy = 1;
    end else if (mClearing) begin
      if (mIdx < 2400) begin
        eWe = 1; eAddr = cellAddr(mIdx); eDin = 32; mIdx++;
      end else begin
        mClearing = 0; eWe = 0; eBusy = 0; mCx = 0; mCy = 0;
      end
    end else begin
      eWe = 0;
      if (clr || (valid && data == 7'h0C)) begin
        mClearing = 1; mIdx = 0; eBusy = 1;
      end else if (valid) begin
        lin = mCy * 80 + mCx;
        if (data >= 7'h20 && data <= 7'h7E) begin
          eWe = 1; eAddr = cellAddr(lin); eDin = int'(data);
          lin = (lin + 1) % 2400;
        end else if (data == 7'h0D) begin
          lin = mCy * 80;
        end else if (data == 7'h0A) begin
          lin = ((mCy + 1) % 30) * 80;
        end else if (data == 7'h08 && lin > 0) begin
          lin = lin - 1;
          eWe = 1; eAddr = cellAddr(lin); eDin = 32;
        end
        mCx = lin % 80;
        mCy = lin / 80;
      end
    end
  endtask

  // Drive one cycle of inputs, check ready before the edge and outputs after it.
  task automatic applyStimulus(input logic rst, input logic valid, input logic [6:0] data, input logic clr);
    i_reset = rst; i_char_valid = valid; i_char_data = data; i_clr_req = clr;
    #1;
    if (!rst) checkOutput("char_ready", 32'(o_char_ready), 32'(!mClearing && !clr));
    @(posedge clk);
    modelStep(rst, valid, data, clr);
    #1;
    checkOutput("ram_we", 32'(o_ram_we), 32'(eWe));
    if (eWe != 0) begin
      checkOutput("ram_addr", 32'(o_ram_addr), 32'(eAddr));
      checkOutput("ram_din", 32'(o_ram_din), 32'(eDin));
    end
    checkOutput("cur_x", 32'(o_cur_x), 32'(mCx));
    checkOutput("cur_y", 32'(o_cur_y), 32'(mCy));
    checkOutput("busy", 32'(o_busy), 32'(eBusy));
    if (o_ram_we === 1'b1 && o_ram_din === 7'h20) begin
      pulses++;
      if (!covered[o_ram_addr]) distinct++;
      covered[o_ram_addr] = 1'b1;
    end
  endtask

  task automatic resetTally();
    for (int i = 0; i < 4096; i++) covered[i] = 1'b0;
    pulses = 0; distinct = 0;
  endtask

  task automatic runSweep(input string tag);
    resetTally();
    for (int i = 0; i < 2500 && mClearing; i++) applyStimulus(1'b0, 1'b0, 7'h00, 1'b0);
    checkOutput({tag, "_pulses"}, 32'(pulses), 32'd2400);
    checkOutput({tag, "_distinct"}, 32'(distinct), 32'd2400);
    checkOutput({tag, "_busyLow"}, 32'(o_busy), 32'd0);
    checkOutput({tag, "_ready"}, 32'(o_char_ready), 32'd1);
  endtask

  initial begin
    logic [6:0] rc;
    logic       rv, rclr;
    int         sel;

    i_reset = 1'b1; i_char_valid = 1'b0; i_char_data = 7'h00; i_clr_req = 1'b0;
    mClearing = 1; mIdx = 0; mCx = 0; mCy = 0;
    eWe = 0; eAddr = 0; eDin = 0; eBusy = 1;

    // Reset held two cycles, then the power-on sweep.
    applyStimulus(1'b1, 1'b0, 7'h00, 1'b0);
    applyStimulus(1'b1, 1'b0, 7'h00, 1'b0);
    checkOutput("rst_addr", 32'(o_ram_addr), 32'd0);
    checkOutput("rst_din", 32'(o_ram_din), 32'd0);
    checkOutput("rst_ready", 32'(o_char_ready), 32'd0);
    runSweep("sweep1");
    checkOutput("sweep1_home", 32'({o_cur_y, o_cur_x}), 32'd0);

    // 'A' then 'B' back to back.
    applyStimulus(1'b0, 1'b1, 7'h41, 1'b0);
    checkOutput("A_addr", 32'(o_ram_addr), 32'h000);
    checkOutput("A_din", 32'(o_ram_din), 32'h41);
    applyStimulus(1'b0, 1'b1, 7'h42, 1'b0);
    checkOutput("B_addr", 32'(o_ram_addr), 32'h001);
    checkOutput("B_we", 32'(o_ram_we), 32'd1);
    checkOutput("AB_cur", 32'({o_cur_y, o_cur_x}), {20'd0, 5'd0, 7'd2});

    // Walk to (79,29) and write there; the cursor wraps home.
    applyStimulus(1'b0, 1'b1, 7'h0D, 1'b0);
    for (int i = 0; i < 29; i++) applyStimulus(1'b0, 1'b1, 7'h0A, 1'b0);
    for (int i = 0; i < 79; i++) applyStimulus(1'b0, 1'b1, 7'h78, 1'b0);
    checkOutput("at_79_29", 32'({o_cur_y, o_cur_x}), {20'd0, 5'd29, 7'd79});
    applyStimulus(1'b0, 1'b1, 7'h41, 1'b0);
    checkOutput("wrap_addr", 32'(o_ram_addr), {20'd0, 5'd29, 7'd79});
    checkOutput("wrap_cur", 32'({o_cur_y, o_cur_x}), 32'd0);

    // LF from (5,3) goes to (0,4) with no write.
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 7'h0A, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 7'h2E, 1'b0);
    applyStimulus(1'b0, 1'b1, 7'h0A, 1'b0);
    checkOutput("lf_we", 32'(o_ram_we), 32'd0);
    checkOutput("lf_cur", 32'({o_cur_y, o_cur_x}), {20'd0, 5'd4, 7'd0});

    // Backspace across a row boundary, then at home.
    applyStimulus(1'b0, 1'b1, 7'h08, 1'b0);
    checkOutput("bs_addr", 32'(o_ram_addr), {20'd0, 5'd3, 7'd79});
    checkOutput("bs_din", 32'(o_ram_din), 32'h20);
    checkOutput("bs_cur", 32'({o_cur_y, o_cur_x}), {20'd0, 5'd3, 7'd79});
    applyStimulus(1'b0, 1'b1, 7'h0D, 1'b0);
    for (int i = 0; i < 27; i++) applyStimulus(1'b0, 1'b1, 7'h0A, 1'b0);
    applyStimulus(1'b0, 1'b1, 7'h08, 1'b0);
    checkOutput("bs_home_we", 32'(o_ram_we), 32'd0);
    checkOutput("bs_home_cur", 32'({o_cur_y, o_cur_x}), 32'd0);

    // Random character stream with occasional clear requests.
    for (int i = 0; i < 400; i++) begin
      rv   = ($urandom % 5) != 0;
      rclr = ($urandom % 150) == 0;
      sel  = $urandom % 10;
      if (sel < 6)       rc = 7'($urandom_range(32, 126));
      else if (sel == 6) rc = 7'h08;
      else if (sel == 7) rc = 7'h0A;
      else if (sel == 8) rc = 7'h0D;
      else               rc = (($urandom % 2) == 0) ? 7'h7F : 7'($urandom_range(0, 7));
      applyStimulus(1'b0, rv, rc, rclr);
    end
    for (int i = 0; i < 2500 && mClearing; i++) applyStimulus(1'b0, 1'b0, 7'h00, 1'b0);

    // clr_req collides with a char; the char is held through the sweep.
    applyStimulus(1'b0, 1'b1, 7'h41, 1'b1);
    checkOutput("clr_busy", 32'(o_busy), 32'd1);
    checkOutput("clr_nowrite", 32'(o_ram_we), 32'd0);
    for (int i = 0; i < 2500 && mClearing; i++) applyStimulus(1'b0, 1'b1, 7'h41, 1'b0);
    applyStimulus(1'b0, 1'b1, 7'h41, 1'b0);
    checkOutput("held_we", 32'(o_ram_we), 32'd1);
    checkOutput("held_addr", 32'(o_ram_addr), 32'd0);
    checkOutput("held_din", 32'(o_ram_din), 32'h41);

    // Form feed starts a sweep; reset lands at cell 1000 and restarts it.
    applyStimulus(1'b0, 1'b1, 7'h0C, 1'b0);
    for (int i = 0; i < 1100 && mIdx < 1000; i++) applyStimulus(1'b0, 1'b0, 7'h00, 1'b0);
    checkOutput("mid_addr", 32'(o_ram_addr), 32'(cellAddr(999)));
    applyStimulus(1'b1, 1'b0, 7'h00, 1'b0);
    checkOutput("midrst_we", 32'(o_ram_we), 32'd0);
    checkOutput("midrst_cur", 32'({o_cur_y, o_cur_x}), 32'd0);
    runSweep("sweep2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
